// File: rtl/tb_irq_gen.sv
// Multi-channel interrupt stimulus generator: schedules NUM_IRQ one-shot or
// periodic sources and arbitrates them onto a single req/id/ack handshake,
// flagging acknowledge timeouts, wrong-ID acknowledges and per-channel overruns.
module tb_irq_gen #(
  parameter int unsigned NUM_IRQ     = 4,
  parameter int unsigned IDW         = 5,
  parameter int unsigned CNTW        = 32,
  parameter int unsigned ACK_TIMEOUT = 1024
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IRQ-1:0]      cfg_en,
  input  logic [NUM_IRQ*CNTW-1:0] cfg_start,
  input  logic [NUM_IRQ*CNTW-1:0] cfg_period,
  input  logic [NUM_IRQ*IDW-1:0]  cfg_id,
  input  logic                    irq_ack_i,
  input  logic [IDW-1:0]          irq_ack_id_i,
  output logic                    irq_o,
  output logic [IDW-1:0]          irq_id_o,
  output logic [CNTW-1:0]         cycle_o,
  output logic [15:0]             serviced_cnt_o,
  output logic                    timeout_o,
  output logic                    id_err_o,
  output logic [NUM_IRQ-1:0]      overrun_o
);

  localparam int unsigned SELW = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;
  localparam int unsigned TW   = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_REQ  = 1'b1
  } arb_state_t;

  arb_state_t        state;
  logic [SELW-1:0]   sel;
  logic [TW-1:0]     ack_timer;

  logic [CNTW-1:0]   next_fire [NUM_IRQ];
  logic              loaded;
  logic [NUM_IRQ-1:0] pending;
  logic [NUM_IRQ-1:0] done;

  logic [CNTW-1:0]   fire_at_c [NUM_IRQ];
  logic [NUM_IRQ-1:0] fire_c;
  logic [NUM_IRQ-1:0] clear_c;
  logic              win_vld_c;
  logic [SELW-1:0]   win_idx_c;
  logic [IDW-1:0]    win_id_c;
  logic              ack_c;
  logic              expire_c;

  // Free-running cycle counter, wraps naturally at 2^CNTW.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_o <= '0;
    end else begin
      cycle_o <= cycle_o + CNTW'(1);
    end
  end

  // Fire detection; before the first load the schedule comes straight from cfg_start.
  always_comb begin
    fire_c = '0;
    for (int k = 0; k < int'(NUM_IRQ); k++) begin
      fire_at_c[k] = loaded ? next_fire[k] : cfg_start[k*CNTW +: CNTW];
      fire_c[k]    = cfg_en[k] && !done[k] && (cycle_o == fire_at_c[k]);
    end
  end

  // Lowest-index pending channel wins arbitration.
  always_comb begin
    win_vld_c = 1'b0;
    win_idx_c = '0;
    for (int k = int'(NUM_IRQ) - 1; k >= 0; k--) begin
      if (pending[k]) begin
        win_vld_c = 1'b1;
        win_idx_c = SELW'(k);
      end
    end
    win_id_c = cfg_id[int'(win_idx_c)*IDW +: IDW];
  end

  // Request termination: acknowledge has priority over timeout.
  always_comb begin
    ack_c    = (state == ARB_REQ) && irq_ack_i;
    expire_c = (state == ARB_REQ) && !irq_ack_i && (ack_timer == TW'(ACK_TIMEOUT));
    clear_c  = '0;
    if (ack_c || expire_c) begin
      clear_c = NUM_IRQ'(1) << sel;
    end
  end

  // Per-channel schedule, pending, done and sticky overrun state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      loaded    <= 1'b0;
      pending   <= '0;
      done      <= '0;
      overrun_o <= '0;
      for (int k = 0; k < int'(NUM_IRQ); k++) begin
        next_fire[k] <= '0;
      end
    end else begin
      loaded <= 1'b1;
      for (int k = 0; k < int'(NUM_IRQ); k++) begin
        if (!loaded) begin
          next_fire[k] <= cfg_start[k*CNTW +: CNTW];
        end
        if (fire_c[k]) begin
          // A new fire outranks a same-edge clear so it is never lost.
          if (pending[k]) begin
            overrun_o[k] <= 1'b1;
          end
          pending[k] <= 1'b1;
          if (cfg_period[k*CNTW +: CNTW] != '0) begin
            next_fire[k] <= fire_at_c[k] + cfg_period[k*CNTW +: CNTW];
          end else begin
            done[k] <= 1'b1;
          end
        end else if (clear_c[k]) begin
          pending[k] <= 1'b0;
        end
      end
    end
  end

  // Request/acknowledge arbiter FSM with ack timer and status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ARB_IDLE;
      sel            <= '0;
      irq_o          <= 1'b0;
      irq_id_o       <= '0;
      ack_timer      <= '0;
      serviced_cnt_o <= '0;
      timeout_o      <= 1'b0;
      id_err_o       <= 1'b0;
    end else begin
      timeout_o <= 1'b0;
      id_err_o  <= 1'b0;
      case (state)
        ARB_IDLE: begin
          if (win_vld_c) begin
            state     <= ARB_REQ;
            sel       <= win_idx_c;
            irq_o     <= 1'b1;
            irq_id_o  <= win_id_c;
            ack_timer <= TW'(1);
          end
        end
        ARB_REQ: begin
          if (ack_c) begin
            state     <= ARB_IDLE;
            irq_o     <= 1'b0;
            ack_timer <= '0;
            if (serviced_cnt_o != 16'hFFFF) begin
              serviced_cnt_o <= serviced_cnt_o + 16'd1;
            end
            if (irq_ack_id_i != irq_id_o) begin
              id_err_o <= 1'b1;
            end
          end else if (expire_c) begin
            state     <= ARB_IDLE;
            irq_o     <= 1'b0;
            ack_timer <= '0;
            timeout_o <= 1'b1;
          end else begin
            ack_timer <= ack_timer + TW'(1);
          end
        end
        default: begin
          state <= ARB_IDLE;
          irq_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tb_irq_gen.sv
// Directed bench for tb_irq_gen: a wide-counter instance (ACK_TIMEOUT=1024)
// and a narrow one (CNTW=8, ACK_TIMEOUT=8) share clock and reset.
module tb_tb_irq_gen;

  logic clk;
  logic rst_n;

  // Instance 1: NUM_IRQ=4, IDW=5, CNTW=32, ACK_TIMEOUT=1024
  logic [3:0]   en1;
  logic [127:0] start1;
  logic [127:0] period1;
  logic [19:0]  id1;
  logic         ack1;
  logic [4:0]   ackid1;
  logic         irq1;
  logic [4:0]   irqid1;
  logic [31:0]  cyc1;
  logic [15:0]  serv1;
  logic         to1;
  logic         iderr1;
  logic [3:0]   ovr1;

  // Instance 2: NUM_IRQ=2, IDW=5, CNTW=8, ACK_TIMEOUT=8
  logic [1:0]   en2;
  logic [15:0]  start2;
  logic [15:0]  period2;
  logic [9:0]   id2;
  logic         ack2;
  logic [4:0]   ackid2;
  logic         irq2;
  logic [4:0]   irqid2;
  logic [7:0]   cyc2;
  logic [15:0]  serv2;
  logic         to2;
  logic         iderr2;
  logic [1:0]   ovr2;

  int checks;
  int errors;

  tb_irq_gen #(.NUM_IRQ(4), .IDW(5), .CNTW(32), .ACK_TIMEOUT(1024)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .cfg_en(en1), .cfg_start(start1), .cfg_period(period1), .cfg_id(id1),
    .irq_ack_i(ack1), .irq_ack_id_i(ackid1),
    .irq_o(irq1), .irq_id_o(irqid1), .cycle_o(cyc1), .serviced_cnt_o(serv1),
    .timeout_o(to1), .id_err_o(iderr1), .overrun_o(ovr1)
  );

  tb_irq_gen #(.NUM_IRQ(2), .IDW(5), .CNTW(8), .ACK_TIMEOUT(8)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .cfg_en(en2), .cfg_start(start2), .cfg_period(period2), .cfg_id(id2),
    .irq_ack_i(ack2), .irq_ack_id_i(ackid2),
    .irq_o(irq2), .irq_id_o(irqid2), .cycle_o(cyc2), .serviced_cnt_o(serv2),
    .timeout_o(to2), .id_err_o(iderr2), .overrun_o(ovr2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Hold reset with all inputs cleared; caller programs config before release.
  task automatic hold_reset();
    rst_n = 1'b0;
    en1 = '0; start1 = '0; period1 = '0; id1 = '0; ack1 = 1'b0; ackid1 = '0;
    en2 = '0; start2 = '0; period2 = '0; id2 = '0; ack2 = 1'b0; ackid2 = '0;
    step(2);
  endtask

  // Release at a falling edge so the current cycle has cycle_o == 0.
  task automatic release_reset();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    hold_reset();
    checks++;
    if (irq1 !== 1'b0 || irqid1 !== 5'd0 || cyc1 !== 32'd0 || serv1 !== 16'd0 ||
        to1 !== 1'b0 || iderr1 !== 1'b0 || ovr1 !== 4'd0) begin
      errors++;
      $display("FAIL reset_outputs: irq=%0d id=%0d cyc=%0d serv=%0d to=%0d iderr=%0d ovr=%b expected all 0",
               irq1, irqid1, cyc1, serv1, to1, iderr1, ovr1);
    end
    release_reset();
    checks++;
    if (cyc1 !== 32'd0) begin
      errors++;
      $display("FAIL reset_cycle0: got %0d expected 0", cyc1);
    end
    step(5);
    checks++;
    if (cyc1 !== 32'd5 || cyc2 !== 8'd5) begin
      errors++;
      $display("FAIL cycle_count: got %0d/%0d expected 5/5", cyc1, cyc2);
    end
  endtask

  task automatic test_one_shot();
    int hi;
    hold_reset();
    en1 = 4'b0001;
    start1[31:0] = 32'd100;
    id1[4:0] = 5'd5;
    release_reset();
    step(101);
    checks++;
    if (irq1 !== 1'b0) begin
      errors++;
      $display("FAIL one_shot_pre: irq=%0d expected 0 at cycle 101", irq1);
    end
    step(1);
    checks++;
    if (irq1 !== 1'b1 || irqid1 !== 5'd5 || cyc1 !== 32'd102) begin
      errors++;
      $display("FAIL one_shot_rise: irq=%0d id=%0d cyc=%0d expected 1/5/102", irq1, irqid1, cyc1);
    end
    step(1);
    checks++;
    if (irq1 !== 1'b1 || irqid1 !== 5'd5) begin
      errors++;
      $display("FAIL one_shot_hold103: irq=%0d id=%0d expected 1/5", irq1, irqid1);
    end
    step(1);
    checks++;
    if (irq1 !== 1'b1 || irqid1 !== 5'd5) begin
      errors++;
      $display("FAIL one_shot_hold104: irq=%0d id=%0d expected 1/5", irq1, irqid1);
    end
    ack1 = 1'b1;
    ackid1 = 5'd5;
    step(1);
    ack1 = 1'b0;
    checks++;
    if (irq1 !== 1'b0 || serv1 !== 16'd1 || iderr1 !== 1'b0 || to1 !== 1'b0) begin
      errors++;
      $display("FAIL one_shot_ack: irq=%0d serv=%0d iderr=%0d to=%0d expected 0/1/0/0",
               irq1, serv1, iderr1, to1);
    end
    hi = 0;
    repeat (150) begin
      step(1);
      if (irq1 === 1'b1) hi++;
    end
    checks++;
    if (hi != 0 || serv1 !== 16'd1) begin
      errors++;
      $display("FAIL one_shot_no_refire: high_cycles=%0d serv=%0d expected 0/1", hi, serv1);
    end
  endtask

  task automatic test_arbitration();
    logic exp;
    hold_reset();
    en1 = 4'b0101;
    start1[31:0] = 32'd50;
    start1[95:64] = 32'd50;
    id1[4:0] = 5'd7;
    id1[14:10] = 5'd9;
    release_reset();
    for (int c = 0; c < 60; c++) begin
      if (c >= 48 && c <= 57) begin
        exp = (c == 52 || c == 54);
        checks++;
        if (irq1 !== exp) begin
          errors++;
          $display("FAIL arb_irq_c%0d: got %0d expected %0d", c, irq1, exp);
        end
      end
      if (c == 52) begin
        checks++;
        if (irqid1 !== 5'd7) begin
          errors++;
          $display("FAIL arb_first_id: got %0d expected 7", irqid1);
        end
      end
      if (c == 54) begin
        checks++;
        if (irqid1 !== 5'd9) begin
          errors++;
          $display("FAIL arb_second_id: got %0d expected 9", irqid1);
        end
      end
      ack1 = irq1;
      ackid1 = irqid1;
      step(1);
    end
    ack1 = 1'b0;
    checks++;
    if (serv1 !== 16'd2 || ovr1 !== 4'd0) begin
      errors++;
      $display("FAIL arb_serviced: serv=%0d ovr=%b expected 2/0000", serv1, ovr1);
    end
  endtask

  task automatic test_overrun();
    logic exp;
    hold_reset();
    en1 = 4'b0010;
    start1[63:32] = 32'd10;
    period1[63:32] = 32'd20;
    id1[9:5] = 5'd11;
    release_reset();
    for (int c = 0; c < 66; c++) begin
      if (c >= 10 && c <= 60) begin
        exp = (c >= 12 && c <= 36) || (c == 52);
        checks++;
        if (irq1 !== exp) begin
          errors++;
          $display("FAIL ovr_irq_c%0d: got %0d expected %0d", c, irq1, exp);
        end
      end
      if (c == 30) begin
        checks++;
        if (ovr1 !== 4'b0000) begin
          errors++;
          $display("FAIL ovr_before: got %b expected 0000", ovr1);
        end
      end
      if (c == 31 || c == 60) begin
        checks++;
        if (ovr1 !== 4'b0010) begin
          errors++;
          $display("FAIL ovr_set_c%0d: got %b expected 0010", c, ovr1);
        end
      end
      if (c == 52) begin
        checks++;
        if (irqid1 !== 5'd11) begin
          errors++;
          $display("FAIL ovr_id: got %0d expected 11", irqid1);
        end
      end
      ack1 = (c == 36 || c == 52);
      ackid1 = 5'd11;
      step(1);
    end
    ack1 = 1'b0;
    checks++;
    if (serv1 !== 16'd2) begin
      errors++;
      $display("FAIL ovr_serviced: got %0d expected 2", serv1);
    end
  endtask

  task automatic test_timeout();
    int hi;
    int tos;
    hold_reset();
    en2 = 2'b01;
    start2[7:0] = 8'd20;
    id2[4:0] = 5'd3;
    release_reset();
    hi = 0;
    tos = 0;
    for (int c = 0; c < 50; c++) begin
      if (irq2 === 1'b1) hi++;
      if (to2 === 1'b1) tos++;
      if (c == 22 || c == 29) begin
        checks++;
        if (irq2 !== 1'b1) begin
          errors++;
          $display("FAIL to_irq_high_c%0d: got %0d expected 1", c, irq2);
        end
      end
      if (c == 30) begin
        checks++;
        if (irq2 !== 1'b0 || to2 !== 1'b1) begin
          errors++;
          $display("FAIL to_pulse: irq=%0d to=%0d expected 0/1", irq2, to2);
        end
      end
      if (c == 31) begin
        checks++;
        if (to2 !== 1'b0) begin
          errors++;
          $display("FAIL to_pulse_width: got %0d expected 0", to2);
        end
      end
      step(1);
    end
    checks++;
    if (hi != 8 || tos != 1 || serv2 !== 16'd0) begin
      errors++;
      $display("FAIL to_summary: high=%0d pulses=%0d serv=%0d expected 8/1/0", hi, tos, serv2);
    end
  endtask

  task automatic test_id_mismatch();
    int errs;
    hold_reset();
    en1 = 4'b1000;
    start1[127:96] = 32'd5;
    id1[19:15] = 5'd3;
    release_reset();
    errs = 0;
    for (int c = 0; c < 12; c++) begin
      if (iderr1 === 1'b1) errs++;
      if (c == 5) begin
        checks++;
        if (serv1 !== 16'd0 || irq1 !== 1'b0) begin
          errors++;
          $display("FAIL idm_stray_ack: serv=%0d irq=%0d expected 0/0", serv1, irq1);
        end
      end
      if (c == 7) begin
        checks++;
        if (irq1 !== 1'b1 || irqid1 !== 5'd3) begin
          errors++;
          $display("FAIL idm_req: irq=%0d id=%0d expected 1/3", irq1, irqid1);
        end
      end
      if (c == 8) begin
        checks++;
        if (irq1 !== 1'b0 || iderr1 !== 1'b1 || serv1 !== 16'd1) begin
          errors++;
          $display("FAIL idm_err: irq=%0d iderr=%0d serv=%0d expected 0/1/1", irq1, iderr1, serv1);
        end
      end
      ack1 = (c == 2 || c == 3 || c == 7);
      ackid1 = (c == 7) ? 5'd4 : 5'd1;
      step(1);
    end
    ack1 = 1'b0;
    checks++;
    if (errs != 1) begin
      errors++;
      $display("FAIL idm_pulse_count: got %0d expected 1", errs);
    end
  endtask

  task automatic test_reset_wrap();
    hold_reset();
    en2 = 2'b10;
    start2[15:8] = 8'd250;
    period2[15:8] = 8'd10;
    id2[9:5] = 5'd6;
    release_reset();
    for (int n = 0; n < 263; n++) begin
      if (n == 252) begin
        checks++;
        if (irq2 !== 1'b1 || irqid2 !== 5'd6) begin
          errors++;
          $display("FAIL wrap_first_req: irq=%0d id=%0d expected 1/6", irq2, irqid2);
        end
      end
      if (n == 253) begin
        checks++;
        if (irq2 !== 1'b0) begin
          errors++;
          $display("FAIL wrap_first_ack: irq=%0d expected 0", irq2);
        end
      end
      if (n == 261) begin
        checks++;
        if (irq2 !== 1'b0 || cyc2 !== 8'd5) begin
          errors++;
          $display("FAIL wrap_pre: irq=%0d cyc=%0d expected 0/5", irq2, cyc2);
        end
      end
      if (n == 262) begin
        checks++;
        if (irq2 !== 1'b1 || cyc2 !== 8'd6 || serv2 !== 16'd1) begin
          errors++;
          $display("FAIL wrap_refire: irq=%0d cyc=%0d serv=%0d expected 1/6/1", irq2, cyc2, serv2);
        end
      end
      ack2 = (n == 252);
      ackid2 = 5'd6;
      if (n < 262) step(1);
    end
    ack2 = 1'b0;
    // Drop reset mid-cycle while the request is up; no clock edge in between.
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (irq2 !== 1'b0 || irqid2 !== 5'd0 || cyc2 !== 8'd0 || serv2 !== 16'd0 ||
        to2 !== 1'b0 || iderr2 !== 1'b0 || ovr2 !== 2'd0 || cyc1 !== 32'd0) begin
      errors++;
      $display("FAIL async_reset: irq=%0d id=%0d cyc=%0d serv=%0d to=%0d iderr=%0d ovr=%b cyc1=%0d expected all 0",
               irq2, irqid2, cyc2, serv2, to2, iderr2, ovr2, cyc1);
    end
    @(negedge clk);
    release_reset();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    test_reset();
    test_one_shot();
    test_arbitration();
    test_overrun();
    test_timeout();
    test_id_mismatch();
    test_reset_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tb_irq_gen.md
# tb_irq_gen

Parametrised multi-channel interrupt stimulus generator for the SoC simulation benches. It replaces the single hard-wired `irq_i` driver with NUM_IRQ independently scheduled sources. Each source fires one-shot or periodically at programmed cycle counts and is arbitrated onto one request/ID/acknowledge handshake toward the core. It also reports acknowledge timeouts, ID mismatches and overruns, so the bench can flag interrupt-path bugs.

## Interface
- NUM_IRQ, 4: number of stimulus channels (1..16)
- IDW, 5: width of the interrupt ID
- CNTW, 32: width of the cycle counter and the schedule values
- ACK_TIMEOUT, 1024: cycles irq_o may stay high without an acknowledge (≥1)
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- cfg_en  in  NUM_IRQ  per-channel enable
- cfg_start  in  NUM_IRQ*CNTW  first fire cycle per channel (channel k in bits [k*CNTW +: CNTW])
- cfg_period  in  NUM_IRQ*CNTW  re-fire period; 0 means one-shot
- cfg_id  in  NUM_IRQ*IDW  ID presented for each channel
- irq_ack_i  in  1  acknowledge from the core
- irq_ack_id_i  in  IDW  ID acknowledged by the core
- irq_o  out  1  interrupt request
- irq_id_o  out  IDW  ID of the request in flight
- cycle_o  out  CNTW  free-running cycle counter
- serviced_cnt_o  out  16  number of acknowledged requests, saturating at 16'hFFFF
- timeout_o  out  1  one-cycle pulse when an acknowledge timeout occurs
- id_err_o  out  1  one-cycle pulse when an acknowledge arrives with a wrong ID
- overrun_o  out  NUM_IRQ  sticky per-channel overrun flags

## Operation
- Reset values: every output is 0; all pending flags, done flags and the ack timer are 0. Each channel's next-fire register loads cfg_start on the first cycle after reset.
- cycle_o increments every clock and wraps modulo 2^CNTW.
- Per-channel states:
  - IDLE (not yet fired, or periodic)
  - PENDING
  - DONE (one-shot already fired)
- Fire condition: cfg_en[k], channel not DONE, and cycle_o == next_fire[k].
- Fire action: pending[k] <= 1.
  - If period ≠ 0: next_fire[k] <= next_fire[k] + period, wrapping modulo 2^CNTW.
  - If period = 0: channel goes to DONE.
- Fire while pending[k] is already 1: overrun_o[k] <= 1 (sticky until reset) and pending stays 1. Fires do not queue.
- Deasserting cfg_en[k] blocks new fires only. An existing pending request is still delivered.
- Arbiter states:
  - IDLE: irq_o = 0.
  - REQ: irq_o = 1.
- IDLE → REQ: taken if any pending bit is set and the previous cycle was not REQ. The lowest pending index wins. The winner is latched as `sel`, and irq_id_o <= cfg_id[sel] is held stable throughout REQ.
- REQ → IDLE on acknowledge (irq_o & irq_ack_i at an edge):
  - pending[sel] <= 0.
  - serviced_cnt_o increments.
  - If irq_ack_id_i ≠ irq_id_o, id_err_o pulses. The request still counts as serviced.
- REQ → IDLE on timeout (ack timer reaches ACK_TIMEOUT without an acknowledge):
  - pending[sel] <= 0.
  - timeout_o pulses.
  - serviced_cnt_o is unchanged.
- Acknowledge and timeout in the same cycle: the acknowledge wins and timeout_o stays 0.
- irq_ack_i while irq_o is 0 is ignored and produces no error.
- Asserting rst_n low mid-request drops irq_o immediately (asynchronous) and clears all state.

## Timing
- Fire-to-request latency: cycle_o == S is sampled at an edge that sets pending. irq_o is high in the cycle where cycle_o == S+2, provided the arbiter is IDLE.
- Acknowledge at edge E: irq_o is low in the cycle after E. Back-to-back requests have exactly one low cycle between them.
- Ack timer: counts REQ cycles starting at 1 in the first REQ cycle. Width is $clog2(ACK_TIMEOUT+1). Timeout fires at the edge closing REQ cycle number ACK_TIMEOUT.
- timeout_o and id_err_o are registered and high for exactly one cycle, the first IDLE cycle.
- Outputs are registered. There are no combinational input-to-output paths.

## Test plan
- One-shot timing: channel 0 with start=100, period=0, id=5; core acks 3 cycles after irq_o rises with id 5.
  - irq_o rises at cycle_o=102 and is high for 3 cycles.
  - irq_id_o=5 throughout.
  - serviced_cnt_o=1, and the channel never fires again.
- Same-start arbitration: channels 0 and 2 both with start=50 and immediate acks.
  - Channel 0's ID is served first.
  - Channel 2's request follows after exactly one low cycle.
  - serviced_cnt_o=2.
- Periodic overrun: channel 1 with start=10, period=20; the first ack is withheld for 25 cycles and ACK_TIMEOUT=1024.
  - overrun_o[1]=1 at the fire for cycle 30.
  - After the ack, no second request for that fire.
  - Next request follows the fire at cycle 50.
- Timeout: ACK_TIMEOUT=8 and no ack.
  - irq_o is high for exactly 8 cycles.
  - One timeout_o pulse.
  - serviced_cnt_o=0 and pending is cleared.
- ID mismatch: id=3 is presented and the core acks with id 4.
  - id_err_o pulses once.
  - serviced_cnt_o=1.
- Mid-request reset and wrap: rst_n is pulled low while irq_o=1.
  - irq_o=0 without a clock edge, and all outputs are 0.
  - With CNTW=8, start=250 and period=10, the next fire is at cycle_o=4 after wrap.
